fir_out_decim: RTL and testbench
================================

# fir_out_decim

Output stage placed directly downstream of the FIR filter. It takes the full-width filter result every clock, rounds it, scales it down by a fixed shift and saturates it to the output width. It then decimates by a run-time ratio and buffers the kept samples in a small FIFO with a valid/ready output handshake. Sticky flags report clipping and FIFO overflow.

## Interface
- IWIDTH, 33, signed input width (FIR result width for 16x16-bit data and 2 taps)
- OWIDTH, 16, signed output width
- SHIFT, 15, arithmetic right shift applied after rounding; legal range 1..IWIDTH-1
- DEPTH, 4, FIFO entries; power of two, at least 2
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- in  in  IWIDTH  signed filter result
- in_en  in  1  qualifies `in` in the current cycle
- decim  in  8  decimation ratio D; the values 0 and 1 both mean no decimation
- clr_flags  in  1  synchronous clear of `sat` and `ovf`
- out_data  out  OWIDTH  signed head-of-FIFO sample
- out_valid  out  1  FIFO not empty
- out_ready  in  1  consumer accepts `out_data` when `out_valid` is also high
- sat  out  1  sticky: a sample with `in_en` high was clipped
- ovf  out  1  sticky: a kept sample was dropped because the FIFO was full

## Operation
- Stage 1 (rounding and saturation):
  - Compute r = (in + 2^(SHIFT-1)) >>> SHIFT. The addition is done in IWIDTH+1 bits, so it cannot wrap.
  - If r > 2^(OWIDTH-1)-1, the output is 2^(OWIDTH-1)-1.
  - If r < -2^(OWIDTH-1), the output is -2^(OWIDTH-1).
  - Otherwise the output is r truncated to OWIDTH bits.
  - Registered into s1_data when in_en=1. A clip sets `sat`.
- Decimator:
  - Counter cnt advances only on cycles with in_en=1. It runs 0..Dm-1 and then wraps to 0, where Dm = max(decim,1).
  - The sample taken while cnt==0 is kept: s1_keep is registered as in_en && cnt==0.
  - If `decim` changes and cnt >= Dm-1, the next in_en cycle wraps cnt to 0.
- FIFO:
  - Show-ahead: `out_data` always shows the oldest entry.
  - Push: s1_keep=1. Pop: out_valid && out_ready.
  - Full with push and no pop: the new sample is dropped and `ovf` sets; stored contents are unchanged.
  - Full with push and pop in the same cycle: both happen, and the count stays at DEPTH.
  - Empty: `out_valid`=0, `out_data` holds its last value, and any pop attempt is ignored.
  - Read and write pointers wrap modulo DEPTH. A count of DEPTH+1 states distinguishes full from empty.
- Flags:
  - `clr_flags`=1 clears `sat` and `ovf` at the next edge.
  - If a set condition occurs in the same cycle, the set wins and the flag stays 1.

## Timing
- Reset values:
  - Outputs: out_data=0, out_valid=0, sat=0, ovf=0.
  - Internal state: cnt=0, FIFO empty, s1_keep=0.
- Reset asserted mid-operation: all FIFO contents and pending stage-1 data are discarded immediately.
- After rst_n deasserts, the first in_en sample has cnt==0 and is therefore kept.
- Latency:
  - A sample presented with in_en=1 in cycle k is registered at the end of cycle k.
  - It is written into the FIFO at the end of cycle k+1.
  - If the FIFO was empty, it appears on out_data with out_valid=1 in cycle k+2.
- Throughput: one input per clock. With Dm=1 and out_ready held at 1, the output also sustains one sample per clock.
- `out_valid` never depends combinationally on `out_ready`. Once asserted, it stays asserted with `out_data` stable until popped.
- `sat` rises in cycle k+1 for a clipped sample presented in cycle k.
- `ovf` rises in cycle k+2 for a sample presented in cycle k and dropped at a full FIFO.

## Test plan
Default parameters for all scenarios.
- Rounding, decim=1, out_ready=1:
  - in=16384 -> out 1.
  - in=16383 -> out 0.
  - in=-16384 -> out 0.
  - in=-16385 -> out -1.
  - Each appears 2 cycles after it is presented; sat stays 0.
- Saturation:
  - in=2^30 -> 32767 with sat=1.
  - in=-2^30 -> -32768 with sat still 0 after a preceding clr_flags.
  - in=-2^30-2^15 -> -32768 with sat=1.
  - clr_flags pulsed alongside a new clip -> sat stays 1.
- Decimation: decim=4, in_en=1, in=n*2^15 for n=0..11 -> outputs 0,4,8. decim=0 -> every sample is output.
- Backpressure: decim=1, out_ready=0, inputs 1..6 (scaled by 2^15):
  - Out_valid rises 2 cycles after the first sample.
  - Samples 5 and 6 are dropped and ovf=1.
  - Setting out_ready=1 then drains 1,2,3,4 in order, with out_valid falling after 4.
- Full FIFO with simultaneous push and pop: FIFO filled with 1..4, out_ready=1, sample 5 pushed in the pop cycle -> output stream 1,2,3,4,5 and ovf=0.
- Reset mid-stream: rst_n pulsed low with 3 entries stored and in_en gaps active:
  - out_valid=0, sat=0, ovf=0 immediately.
  - With decim=3, the first post-reset sample is the first one output.

Source files
------------

// File: rtl/fir_out_decim.sv
// rtl/fir_out_decim.sv - FIR output stage: round, scale, saturate, decimate, FIFO with valid/ready
module fir_out_decim #(
  parameter int IWIDTH = 33,
  parameter int OWIDTH = 16,
  parameter int SHIFT  = 15,
  parameter int DEPTH  = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic signed [IWIDTH-1:0] in_i,
  input  logic                     in_en_i,
  input  logic [7:0]               decim_i,
  input  logic                     clr_flags_i,
  output logic signed [OWIDTH-1:0] out_data_o,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic                     sat_o,
  output logic                     ovf_o
);
  localparam int AW = $clog2(DEPTH);
  // Rounding offset and clip limits, all held at IWIDTH+1 bits so the add cannot wrap.
  localparam logic signed [IWIDTH:0] RND  = {{IWIDTH{1'b0}}, 1'b1} << (SHIFT - 1);
  localparam logic signed [IWIDTH:0] OMAX = {{(IWIDTH-OWIDTH+2){1'b0}}, {(OWIDTH-1){1'b1}}};
  localparam logic signed [IWIDTH:0] OMIN = {{(IWIDTH-OWIDTH+2){1'b1}}, {(OWIDTH-1){1'b0}}};
  localparam logic [AW:0]            FULL = (AW+1)'(DEPTH);

  logic signed [IWIDTH:0]   sum_c, r_c;
  logic                     hi_c, lo_c;
  logic signed [OWIDTH-1:0] s1_val_c;
  logic [7:0]               dm_c;
  logic                     push_c, pop_c, full_c, wr_c;

  logic signed [OWIDTH-1:0] s1_data_q, s1_data_d;
  logic                     s1_keep_q, s1_keep_d;
  logic [7:0]               cnt_q, cnt_d;
  logic signed [OWIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]            wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]              count_q, count_d;
  logic signed [OWIDTH-1:0] last_q, last_d;
  logic                     sat_q, sat_d, ovf_q, ovf_d;

  assign sum_c    = $signed({in_i[IWIDTH-1], in_i}) + RND;
  assign r_c      = sum_c >>> SHIFT;
  assign hi_c     = r_c > OMAX;
  assign lo_c     = r_c < OMIN;
  assign s1_val_c = hi_c ? OMAX[OWIDTH-1:0] : (lo_c ? OMIN[OWIDTH-1:0] : r_c[OWIDTH-1:0]);

  // A ratio of 0 behaves like 1 (keep everything).
  assign dm_c = (decim_i == 8'd0) ? 8'd1 : decim_i;

  assign push_c      = s1_keep_q;
  assign full_c      = (count_q == FULL);
  assign out_valid_o = (count_q != '0);
  assign pop_c       = out_valid_o && out_ready_i;
  // A push into a full FIFO only lands if the head leaves in the same cycle.
  assign wr_c        = push_c && (!full_c || pop_c);

  // When empty, keep presenting the last sample that was popped.
  assign out_data_o = out_valid_o ? mem_q[rptr_q] : last_q;
  assign sat_o      = sat_q;
  assign ovf_o      = ovf_q;

  // Next-state for stage 1, decimation counter, FIFO bookkeeping and sticky flags.
  always_comb begin
    s1_data_d = s1_data_q;
    cnt_d     = cnt_q;
    s1_keep_d = in_en_i && (cnt_q == 8'd0);
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    last_d    = last_q;
    count_d   = count_q;
    if (in_en_i) begin
      s1_data_d = s1_val_c;
      // >= rather than == so a ratio lowered below the current count still wraps.
      cnt_d     = (cnt_q >= dm_c - 8'd1) ? 8'd0 : cnt_q + 8'd1;
    end
    if (wr_c) begin
      wptr_d = wptr_q + AW'(1);
    end
    if (pop_c) begin
      rptr_d = rptr_q + AW'(1);
      last_d = mem_q[rptr_q];
    end
    case ({wr_c, pop_c})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
    sat_d = (in_en_i && (hi_c || lo_c)) || (sat_q && !clr_flags_i);
    ovf_d = (push_c && full_c && !pop_c) || (ovf_q && !clr_flags_i);
  end

  // Control and datapath registers; reset discards pending and stored samples.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_data_q <= '0;
      s1_keep_q <= 1'b0;
      cnt_q     <= 8'd0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      last_q    <= '0;
      sat_q     <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      s1_data_q <= s1_data_d;
      s1_keep_q <= s1_keep_d;
      cnt_q     <= cnt_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      count_q   <= count_d;
      last_q    <= last_d;
      sat_q     <= sat_d;
      ovf_q     <= ovf_d;
    end
  end

  // FIFO storage; validity is tracked by count_q so the array needs no reset.
  always_ff @(posedge clk_i) begin
    if (wr_c) begin
      mem_q[wptr_q] <= s1_data_q;
    end
  end
endmodule

// File: tb/tb_fir_out_decim.sv
// tb/tb_fir_out_decim.sv - self-checking bench for fir_out_decim
module tb_fir_out_decim;
  localparam int DEPTH = 4;

  logic               clk = 1'b0;
  logic               rst_n = 1'b1;
  logic signed [32:0] in_v = '0;
  logic               in_en = 1'b0;
  logic [7:0]         decim = 8'd1;
  logic               clr = 1'b0;
  logic               out_ready = 1'b0;
  logic signed [15:0] out_data;
  logic               out_valid, sat, ovf;

  int checks = 0;
  int errors = 0;

  fir_out_decim dut (
    .clk_i(clk), .rst_ni(rst_n), .in_i(in_v), .in_en_i(in_en), .decim_i(decim),
    .clr_flags_i(clr), .out_data_o(out_data), .out_valid_o(out_valid),
    .out_ready_i(out_ready), .sat_o(sat), .ovf_o(ovf)
  );

  always #5 clk = ~clk;

  // Reference model: stage-1 value, keep flag, queue of stored samples.
  int m_q[$];
  int m_last, m_s1, m_cnt;
  bit m_keep, m_sat, m_ovf;

  function automatic int m_round(input longint v, output bit clip);
    longint r;
    r = (v + 16384) >>> 15;
    clip = 1'b0;
    if (r > 32767) begin clip = 1'b1; return 32767; end
    if (r < -32768) begin clip = 1'b1; return -32768; end
    return int'(r);
  endfunction

  function automatic void model_reset();
    m_q.delete();
    m_last = 0; m_s1 = 0; m_cnt = 0;
    m_keep = 0; m_sat = 0; m_ovf = 0;
  endfunction

  function automatic void model_edge();
    bit pop, clip, ovf_set;
    int v, dm;
    pop = (m_q.size() > 0) && out_ready;
    ovf_set = 0;
    if (pop) m_last = m_q.pop_front();
    if (m_keep) begin
      if (m_q.size() < DEPTH) m_q.push_back(m_s1);
      else ovf_set = 1;
    end
    v = m_round(longint'(in_v), clip);
    m_sat = (in_en && clip) || (m_sat && !clr);
    m_ovf = ovf_set || (m_ovf && !clr);
    m_keep = in_en && (m_cnt == 0);
    if (in_en) begin
      m_s1 = v;
      dm = (decim == 0) ? 1 : int'(decim);
      m_cnt = (m_cnt + 1 >= dm) ? 0 : m_cnt + 1;
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_edge();
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; in_en = 0; in_v = '0; clr = 0; out_ready = 0; decim = 8'd1;
    model_reset();
    tick(); tick();
    rst_n = 1'b1;
  endtask

  function automatic logic signed [32:0] rand_in();
    logic [63:0] t;
    longint x;
    case ($urandom_range(0, 3))
      0: begin t = {$urandom, $urandom}; return t[32:0]; end
      1: begin x = longint'($urandom_range(0, 1 << 25)) - (1 << 24); return 33'(x); end
      2: begin
        x = (longint'(1) << 30) + longint'($urandom_range(0, 1 << 17)) - (1 << 16);
        if ($urandom_range(0, 1) == 1) x = -x;
        return 33'(x);
      end
      default: begin
        x = (longint'($urandom_range(0, 200)) - 100) * 32768 + 16384 - longint'($urandom_range(0, 1));
        return 33'(x);
      end
    endcase
  endfunction

  task automatic test_reset();
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b expected 0", out_valid); end
    checks++; if (out_data !== 16'sd0) begin errors++; $display("FAIL reset_data: got %0d expected 0", out_data); end
    checks++; if (sat !== 1'b0 || ovf !== 1'b0) begin errors++; $display("FAIL reset_flags: got sat=%0b ovf=%0b expected 0 0", sat, ovf); end
    tick(); tick();
    rst_n = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_idle_valid: got %0b expected 0", out_valid); end
  endtask

  task automatic test_rounding();
    longint rv[4] = '{16384, 16383, -16384, -16385};
    int     re[4] = '{1, 0, 0, -1};
    do_reset();
    decim = 8'd1; out_ready = 1'b1;
    for (int t = 0; t < 6; t++) begin
      if (t < 4) begin in_v = 33'(rv[t]); in_en = 1'b1; end
      else in_en = 1'b0;
      tick();
      if (t == 0) begin
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL round_latency: got valid %0b expected 0", out_valid); end
      end else if (t <= 4) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== 16'(re[t-1])) begin
          errors++; $display("FAIL round_%0d: got valid=%0b data=%0d expected 1 %0d", t - 1, out_valid, out_data, re[t-1]);
        end
      end
    end
    checks++; if (sat !== 1'b0) begin errors++; $display("FAIL round_sat: got %0b expected 0", sat); end
  endtask

  task automatic test_saturation();
    do_reset();
    decim = 8'd1; out_ready = 1'b1;
    clr = 1'b1; tick(); clr = 1'b0;
    in_v = 33'(longint'(1) << 30); in_en = 1'b1; tick(); in_en = 1'b0;
    checks++; if (sat !== 1'b1) begin errors++; $display("FAIL sat_pos_rise: got %0b expected 1", sat); end
    tick();
    checks++; if (out_valid !== 1'b1 || out_data !== 16'sd32767) begin errors++; $display("FAIL sat_pos_data: got %0d expected 32767", out_data); end
    clr = 1'b1; tick(); clr = 1'b0;
    checks++; if (sat !== 1'b0) begin errors++; $display("FAIL sat_clear: got %0b expected 0", sat); end
    in_v = 33'(-(longint'(1) << 30)); in_en = 1'b1; tick(); in_en = 1'b0;
    checks++; if (sat !== 1'b0) begin errors++; $display("FAIL sat_neg_exact: got %0b expected 0", sat); end
    tick();
    checks++; if (out_data !== 16'h8000) begin errors++; $display("FAIL sat_neg_exact_data: got %0d expected -32768", out_data); end
    in_v = 33'(-(longint'(1) << 30) - 32768); in_en = 1'b1; tick(); in_en = 1'b0;
    checks++; if (sat !== 1'b1) begin errors++; $display("FAIL sat_neg_clip: got %0b expected 1", sat); end
    tick();
    checks++; if (out_data !== 16'h8000) begin errors++; $display("FAIL sat_neg_clip_data: got %0d expected -32768", out_data); end
    clr = 1'b1; in_v = 33'(longint'(1) << 30); in_en = 1'b1; tick(); in_en = 1'b0; clr = 1'b0;
    checks++; if (sat !== 1'b1) begin errors++; $display("FAIL sat_set_wins: got %0b expected 1", sat); end
    clr = 1'b1; tick(); clr = 1'b0;
    checks++; if (sat !== 1'b0) begin errors++; $display("FAIL sat_clear2: got %0b expected 0", sat); end
  endtask

  task automatic test_decimation();
    int got[$];
    int de[3] = '{0, 4, 8};
    do_reset();
    decim = 8'd4; out_ready = 1'b1;
    for (int t = 0; t < 16; t++) begin
      if (t < 12) begin in_v = 33'(longint'(t) << 15); in_en = 1'b1; end
      else in_en = 1'b0;
      tick();
      if (out_valid) got.push_back(int'(out_data));
    end
    checks++;
    if (got.size() != 3) begin errors++; $display("FAIL decim4_count: got %0d expected 3", got.size()); end
    else for (int i = 0; i < 3; i++) begin
      checks++; if (got[i] != de[i]) begin errors++; $display("FAIL decim4_val%0d: got %0d expected %0d", i, got[i], de[i]); end
    end
    got.delete();
    decim = 8'd0;
    for (int t = 0; t < 10; t++) begin
      if (t < 6) begin in_v = 33'(longint'(t + 20) << 15); in_en = 1'b1; end
      else in_en = 1'b0;
      tick();
      if (out_valid) got.push_back(int'(out_data));
    end
    checks++;
    if (got.size() != 6) begin errors++; $display("FAIL decim0_count: got %0d expected 6", got.size()); end
    else for (int i = 0; i < 6; i++) begin
      checks++; if (got[i] != i + 20) begin errors++; $display("FAIL decim0_val%0d: got %0d expected %0d", i, got[i], i + 20); end
    end
  endtask

  task automatic test_backpressure();
    int got[$];
    do_reset();
    decim = 8'd1; out_ready = 1'b0;
    for (int t = 0; t < 6; t++) begin
      in_v = 33'(longint'(t + 1) << 15); in_en = 1'b1;
      tick();
      if (t == 0) begin
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_valid_early: got %0b expected 0", out_valid); end
      end
      if (t == 1) begin
        checks++; if (out_valid !== 1'b1 || out_data !== 16'sd1) begin errors++; $display("FAIL bp_valid_rise: got valid=%0b data=%0d expected 1 1", out_valid, out_data); end
      end
      if (t == 4) begin
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL bp_ovf_early: got %0b expected 0", ovf); end
      end
      if (t == 5) begin
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL bp_ovf_rise: got %0b expected 1", ovf); end
      end
    end
    in_en = 1'b0;
    tick();
    checks++; if (ovf !== 1'b1 || out_data !== 16'sd1) begin errors++; $display("FAIL bp_hold: got ovf=%0b data=%0d expected 1 1", ovf, out_data); end
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (out_valid) got.push_back(int'(out_data));
      tick();
    end
    checks++;
    if (got.size() != 4) begin errors++; $display("FAIL bp_drain_count: got %0d expected 4", got.size()); end
    else for (int i = 0; i < 4; i++) begin
      checks++; if (got[i] != i + 1) begin errors++; $display("FAIL bp_drain%0d: got %0d expected %0d", i, got[i], i + 1); end
    end
    checks++; if (out_valid !== 1'b0 || out_data !== 16'sd4) begin errors++; $display("FAIL bp_empty: got valid=%0b data=%0d expected 0 4", out_valid, out_data); end
    out_ready = 1'b0;
  endtask

  task automatic test_full_push_pop();
    int got[$];
    do_reset();
    decim = 8'd1; out_ready = 1'b0;
    for (int t = 0; t < 4; t++) begin
      in_v = 33'(longint'(t + 1) << 15); in_en = 1'b1; tick();
    end
    in_en = 1'b0; tick();
    in_v = 33'(longint'(5) << 15); in_en = 1'b1; tick(); in_en = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (out_valid) got.push_back(int'(out_data));
      tick();
    end
    checks++;
    if (got.size() != 5) begin errors++; $display("FAIL fpp_count: got %0d expected 5", got.size()); end
    else for (int i = 0; i < 5; i++) begin
      checks++; if (got[i] != i + 1) begin errors++; $display("FAIL fpp_val%0d: got %0d expected %0d", i, got[i], i + 1); end
    end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL fpp_ovf: got %0b expected 0", ovf); end
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    int got[$];
    int exp_q[$];
    int ne;
    do_reset();
    decim = 8'd1; out_ready = 1'b0;
    in_v = 33'(longint'(1) << 30); in_en = 1'b1; tick();
    in_en = 1'b0; tick();
    in_v = 33'(longint'(2) << 15); in_en = 1'b1; tick();
    in_en = 1'b0; tick();
    in_v = 33'(longint'(3) << 15); in_en = 1'b1; tick();
    in_v = 33'(longint'(4) << 15); in_en = 1'b1; tick();
    in_en = 1'b0;
    checks++; if (out_valid !== 1'b1 || sat !== 1'b1) begin errors++; $display("FAIL rm_pre: got valid=%0b sat=%0b expected 1 1", out_valid, sat); end
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++; if (out_valid !== 1'b0 || sat !== 1'b0 || ovf !== 1'b0) begin errors++; $display("FAIL rm_async: got valid=%0b sat=%0b ovf=%0b expected 0 0 0", out_valid, sat, ovf); end
    tick();
    rst_n = 1'b1;
    decim = 8'd3; out_ready = 1'b1;
    ne = 0;
    for (int t = 0; t < 24; t++) begin
      in_en = (t < 20) && ($urandom_range(0, 2) != 0);
      in_v = 33'(longint'(10 + ne) << 15);
      if (in_en) begin
        if (ne % 3 == 0) exp_q.push_back(10 + ne);
        ne++;
      end
      tick();
      if (out_valid) got.push_back(int'(out_data));
    end
    in_en = 1'b0;
    checks++;
    if (got.size() == 0 || got[0] != 10) begin errors++; $display("FAIL rm_first: got %0d expected 10", (got.size() == 0) ? -1 : got[0]); end
    checks++;
    if (got != exp_q) begin errors++; $display("FAIL rm_stream: got %0d samples expected %0d", got.size(), exp_q.size()); end
  endtask

  task automatic test_random();
    int ev;
    do_reset();
    for (int i = 0; i < 1200; i++) begin
      in_v = rand_in();
      in_en = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 19) == 0) decim = 8'($urandom_range(0, 5));
      case ((i / 100) % 3)
        0: out_ready = ($urandom_range(0, 9) < 2);
        1: out_ready = ($urandom_range(0, 9) < 9);
        default: out_ready = ($urandom_range(0, 1) == 1);
      endcase
      clr = ($urandom_range(0, 15) == 0);
      tick();
      ev = (m_q.size() > 0) ? m_q[0] : m_last;
      checks++; if (out_valid !== (m_q.size() > 0)) begin errors++; $display("FAIL rand_valid cyc %0d: got %0b expected %0b", i, out_valid, m_q.size() > 0); end
      checks++; if (out_data !== 16'(ev)) begin errors++; $display("FAIL rand_data cyc %0d: got %0d expected %0d", i, out_data, ev); end
      checks++; if (sat !== m_sat) begin errors++; $display("FAIL rand_sat cyc %0d: got %0b expected %0b", i, sat, m_sat); end
      checks++; if (ovf !== m_ovf) begin errors++; $display("FAIL rand_ovf cyc %0d: got %0b expected %0b", i, ovf, m_ovf); end
    end
    clr = 1'b0; in_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_rounding();
    test_saturation();
    test_decimation();
    test_backpressure();
    test_full_push_pop();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
